fpga_core_scan: RTL and testbench
=================================

FPGA_CORE_SCAN -- requirements
Module: fpga_core

Interface
REQ-001 Parameter FPGA_IO_SIZE, default 144, number of fabric I/O pads.
REQ-002 Parameter FPGA_SCANCHAIN_SIZE, default 2304, number of user flip-flops on the scan chain; SHALL be >= FPGA_IO_SIZE.
REQ-003 clk  input  1  sole clock; all sequential logic SHALL be on its rising edge.
REQ-004 greset_n  input  1  asynchronous, active-low reset.
REQ-005 prog_clk  input  1  configuration shift strobe, sampled as a level-sensitive enable on clk; it is not a clock.
REQ-006 Test_en  input  1  1 = scan-shift mode, 0 = functional mode.
REQ-007 ccff_head  input  1  configuration-chain serial input.
REQ-008 ccff_tail  output  1  configuration-chain serial output.
REQ-009 sc_head  input  1  scan-chain serial input.
REQ-010 sc_tail  output  1  scan-chain serial output.
REQ-011 IO_ISOL_N  input  1  active-low I/O isolation.
REQ-012 gfpga_pad_EMBEDDED_IO_HD_SOC_IN  input  [0:FPGA_IO_SIZE-1]  pad data into the fabric.
REQ-013 gfpga_pad_EMBEDDED_IO_HD_SOC_OUT  output  [0:FPGA_IO_SIZE-1]  pad data out of the fabric.
REQ-014 gfpga_pad_EMBEDDED_IO_HD_SOC_DIR  output  [0:FPGA_IO_SIZE-1]  per-pad direction: 1 = input (pad tristated), 0 = output.

Function
REQ-015 Scan chain: a register ff[0:FPGA_SCANCHAIN_SIZE-1], with ff[0] nearest sc_head.
REQ-016 When Test_en=1, on each clk edge: ff[0] <= sc_head and ff[k] <= ff[k-1].
REQ-017 When Test_en=0, on each clk edge: ff[k] <= SOC_IN[k mod FPGA_IO_SIZE].
REQ-018 sc_tail SHALL equal ff[FPGA_SCANCHAIN_SIZE-1] directly, with no extra register.
REQ-019 Latency: a value on sc_head sampled at edge 1 SHALL appear on sc_tail after edge FPGA_SCANCHAIN_SIZE, i.e. exactly FPGA_SCANCHAIN_SIZE cycles later.
REQ-020 Configuration chain: a register cfg[0:FPGA_IO_SIZE-1], one output-enable bit per pad.
REQ-021 On each clk edge with prog_clk=1: cfg[0] <= ccff_head and cfg[j] <= cfg[j-1]; with prog_clk=0 the chain holds.
REQ-022 ccff_tail SHALL equal cfg[FPGA_IO_SIZE-1].
REQ-023 The configuration chain is independent of Test_en, and the scan chain is independent of prog_clk; both may shift in the same cycle.
REQ-024 Pad j driven (IO_ISOL_N=1 and cfg[j]=1): SOC_OUT[j] = ff[FPGA_SCANCHAIN_SIZE-FPGA_IO_SIZE+j] and SOC_DIR[j] = 0.
REQ-025 Pad j otherwise: SOC_OUT[j] = 0 and SOC_DIR[j] = 1.
REQ-026 IO_ISOL_N=0 SHALL force every SOC_OUT to 0 and every SOC_DIR to 1 combinationally, regardless of cfg.
REQ-027 When Test_en toggles, the mode change SHALL take effect on the next clk edge; there is no flush.

Reset
REQ-028 greset_n=0 SHALL asynchronously clear all ff and cfg bits to 0.
REQ-029 While greset_n=0: sc_tail=0, ccff_tail=0, all SOC_OUT=0 and all SOC_DIR=1.
REQ-030 Release of greset_n SHALL take effect at the next clk edge; reset asserted mid-shift discards all chain contents.

Structure
REQ-031 A shared package fpga_core_pkg SHALL hold default constants FPGA_IO_SIZE_DEF=144 and FPGA_SCANCHAIN_SIZE_DEF=2304.
REQ-032 One sub-module, fpga_shift_chain (parameterised width, async active-low clear, shift-enable, parallel load), SHALL be instantiated for both the scan chain and the configuration chain.

Verification
REQ-033 Reset: greset_n=0 for 1 cycle -> sc_tail=0, ccff_tail=0, SOC_OUT all 0, SOC_DIR all 1.
REQ-034 Scan pulse: Test_en=1, sc_head=1 for cycle 1 then 0 -> sc_tail=1 after edge 2304 and sc_tail=0 for at least the following 3 edges.
REQ-035 Config load: prog_clk=1, shift 144 ones via ccff_head, IO_ISOL_N=1 -> SOC_DIR all 0 and ccff_tail=1.
REQ-036 Isolation: with REQ-035's configuration, drive IO_ISOL_N=0 -> SOC_DIR all 1 and SOC_OUT all 0 immediately.
REQ-037 Functional capture: Test_en=0, SOC_IN=alternating 1010..., configured and not isolated, after one edge -> SOC_OUT equals SOC_IN.
REQ-038 Mid-shift reset: assert greset_n=0 at cycle 1000 of REQ-034 -> sc_tail remains 0 through cycle 2400.

Source files
------------

// File: rtl/fpga_core_pkg.sv
// fpga_core_pkg: default sizing shared by the fabric core and its bench.
package fpga_core_pkg;
  localparam int FPGA_IO_SIZE_DEF        = 144;
  localparam int FPGA_SCANCHAIN_SIZE_DEF = 2304;
endpackage

// File: rtl/fpga_shift_chain.sv
// fpga_shift_chain: serial shift register with parallel load and a tail-end tap window.
module fpga_shift_chain
  import fpga_core_pkg::*;
#(
  parameter int W   = FPGA_IO_SIZE_DEF,
  parameter int TAP = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_shift,
  input  logic           i_load,
  input  logic           i_si,
  input  logic [0:W-1]   i_d,
  output logic [0:TAP-1] o_tap
);
  logic [0:W-1] r_q;
  // Shift wins over load so a chain used in both modes never needs arbitration upstream.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_q <= '0;
    else if (i_shift)
      r_q <= {i_si, r_q[0:W-2]};
    else if (i_load)
      r_q <= i_d;
  assign o_tap = r_q[W-TAP +: TAP];
endmodule

// File: rtl/fpga_core_scan.sv
// fpga_core_scan: fabric core with a user scan chain and a per-pad output-enable config chain.
module fpga_core_scan
  import fpga_core_pkg::*;
#(
  parameter int FPGA_IO_SIZE        = FPGA_IO_SIZE_DEF,
  parameter int FPGA_SCANCHAIN_SIZE = FPGA_SCANCHAIN_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    greset_n,
  input  logic                    prog_clk,
  input  logic                    Test_en,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic                    sc_head,
  output logic                    sc_tail,
  input  logic                    IO_ISOL_N,
  input  logic [0:FPGA_IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [0:FPGA_IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [0:FPGA_IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
);
  logic [0:FPGA_SCANCHAIN_SIZE-1] w_cap;
  logic [0:FPGA_IO_SIZE-1]        w_ff_tap;
  logic [0:FPGA_IO_SIZE-1]        w_cfg;
  logic [0:FPGA_IO_SIZE-1]        w_drv;
  // Each flop captures the pad that shares its index modulo the pad count.
  for (genvar k = 0; k < FPGA_SCANCHAIN_SIZE; k++) begin : g_cap
    assign w_cap[k] = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k % FPGA_IO_SIZE];
  end
  fpga_shift_chain #(.W(FPGA_SCANCHAIN_SIZE), .TAP(FPGA_IO_SIZE)) u_scan (
    .clk     (clk),
    .rst_n   (greset_n),
    .i_shift (Test_en),
    .i_load  (!Test_en),
    .i_si    (sc_head),
    .i_d     (w_cap),
    .o_tap   (w_ff_tap)
  );
  fpga_shift_chain #(.W(FPGA_IO_SIZE), .TAP(FPGA_IO_SIZE)) u_cfg (
    .clk     (clk),
    .rst_n   (greset_n),
    .i_shift (prog_clk),
    .i_load  (1'b0),
    .i_si    (ccff_head),
    .i_d     ('0),
    .o_tap   (w_cfg)
  );
  assign w_drv                            = {FPGA_IO_SIZE{IO_ISOL_N}} & w_cfg;
  assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = w_drv & w_ff_tap;
  assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = ~w_drv;
  assign sc_tail                          = w_ff_tap[FPGA_IO_SIZE-1];
  assign ccff_tail                        = w_cfg[FPGA_IO_SIZE-1];
endmodule

// File: tb/tb_fpga_core_scan.sv
// tb_fpga_core_scan: scoreboard bench for scan latency, config chain, isolation and capture.
module tb_fpga_core_scan;
  import fpga_core_pkg::*;
  localparam int IO = FPGA_IO_SIZE_DEF;
  localparam int SC = FPGA_SCANCHAIN_SIZE_DEF;
  logic clk = 1'b0;
  logic greset_n = 1'b0;
  logic prog_clk = 1'b0;
  logic Test_en = 1'b0;
  logic ccff_head = 1'b0;
  logic ccff_tail;
  logic sc_head = 1'b0;
  logic sc_tail;
  logic IO_ISOL_N = 1'b0;
  logic [0:IO-1] pad_in = '0;
  logic [0:IO-1] pad_out;
  logic [0:IO-1] pad_dir;
  int n_cmp = 0;
  int n_err = 0;
  fpga_core_scan dut (
    .clk                              (clk),
    .greset_n                         (greset_n),
    .prog_clk                         (prog_clk),
    .Test_en                          (Test_en),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .sc_head                          (sc_head),
    .sc_tail                          (sc_tail),
    .IO_ISOL_N                        (IO_ISOL_N),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    greset_n = 1'b0;
    #1;
    tick;
    n_cmp += 4;
    if (sc_tail !== 1'b0) begin n_err++; $display("FAIL reset_sc_tail got %b want 0", sc_tail); end
    if (ccff_tail !== 1'b0) begin n_err++; $display("FAIL reset_ccff_tail got %b want 0", ccff_tail); end
    if (pad_out !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", pad_out); end
    if (pad_dir !== '1) begin n_err++; $display("FAIL reset_dir got %h want all ones", pad_dir); end
    greset_n = 1'b1;
  endtask
  // Every scan edge pushes the sampled head bit; it must reappear on sc_tail SC edges later.
  task automatic test_scan_pulse(input int rst_at);
    logic sb[$];
    logic exp;
    Test_en = 1'b1;
    prog_clk = 1'b0;
    for (int k = 1; k <= 2400; k++) begin
      sc_head = (k == 1);
      tick;
      sb.push_back(sc_head);
      exp = (sb.size() == SC) ? sb.pop_front() : 1'b0;
      n_cmp++;
      if (sc_tail !== exp) begin
        n_err++;
        $display("FAIL scan_tail(rst_at=%0d) edge %0d got %b want %b", rst_at, k, sc_tail, exp);
      end
      if (rst_at == 0 && k == SC) begin
        n_cmp++;
        if (sc_tail !== 1'b1) begin n_err++; $display("FAIL scan_latency got %b want 1", sc_tail); end
      end
      if (k == rst_at) begin
        greset_n = 1'b0;
        #1;
        n_cmp += 2;
        if (sc_tail !== 1'b0) begin n_err++; $display("FAIL midreset_sc_tail got %b want 0", sc_tail); end
        if (pad_dir !== '1) begin n_err++; $display("FAIL midreset_dir got %h want all ones", pad_dir); end
        sb.delete();
        greset_n = 1'b1;
      end
    end
    sc_head = 1'b0;
  endtask
  task automatic test_config;
    test_reset;
    IO_ISOL_N = 1'b1;
    prog_clk = 1'b1;
    ccff_head = 1'b1;
    for (int k = 1; k <= IO; k++) begin
      tick;
      if (k == IO - 1) begin
        n_cmp++;
        if (ccff_tail !== 1'b0) begin n_err++; $display("FAIL cfg_tail_early got %b want 0", ccff_tail); end
      end
    end
    prog_clk = 1'b0;
    n_cmp += 2;
    if (ccff_tail !== 1'b1) begin n_err++; $display("FAIL cfg_tail got %b want 1", ccff_tail); end
    if (pad_dir !== '0) begin n_err++; $display("FAIL cfg_dir got %h want 0", pad_dir); end
  endtask
  // First bit shifted in ends up at the far pad, so pad j holds the bit sent at position IO-1-j.
  task automatic test_config_order;
    logic pat[$];
    logic [0:IO-1] exp_dir;
    prog_clk = 1'b1;
    for (int k = 0; k < IO; k++) begin
      ccff_head = 1'($urandom_range(0, 1));
      pat.push_back(ccff_head);
      tick;
    end
    prog_clk = 1'b0;
    for (int j = 0; j < IO; j++) exp_dir[j] = ~pat[IO-1-j];
    n_cmp += 2;
    if (pad_dir !== exp_dir) begin n_err++; $display("FAIL cfg_order_dir got %h want %h", pad_dir, exp_dir); end
    if (ccff_tail !== pat[0]) begin n_err++; $display("FAIL cfg_order_tail got %b want %b", ccff_tail, pat[0]); end
    prog_clk = 1'b1;
    ccff_head = 1'b1;
    repeat (IO) tick;
    prog_clk = 1'b0;
  endtask
  task automatic test_capture;
    logic [0:IO-1] v;
    Test_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < IO; j++) v[j] = ((j % 2) == p);
      pad_in = v;
      tick;
      n_cmp += 2;
      if (pad_out !== v) begin n_err++; $display("FAIL capture%0d got %h want %h", p, pad_out, v); end
      if (pad_dir !== '0) begin n_err++; $display("FAIL capture%0d_dir got %h want 0", p, pad_dir); end
    end
    for (int j = 0; j < IO; j++) v[j] = (j % 2) == 0;
    pad_in = v;
    tick;
  endtask
  task automatic test_isolation;
    logic [0:IO-1] v;
    for (int j = 0; j < IO; j++) v[j] = (j % 2) == 0;
    IO_ISOL_N = 1'b0;
    #1;
    n_cmp += 2;
    if (pad_dir !== '1) begin n_err++; $display("FAIL isol_dir got %h want all ones", pad_dir); end
    if (pad_out !== '0) begin n_err++; $display("FAIL isol_out got %h want 0", pad_out); end
    IO_ISOL_N = 1'b1;
    #1;
    n_cmp++;
    if (pad_out !== v) begin n_err++; $display("FAIL unisol_out got %h want %h", pad_out, v); end
  endtask
  // Switching to scan on the next edge shifts the captured window by one: pad 0 takes capture of pad IO-1.
  task automatic test_mode_toggle;
    logic [0:IO-1] exp;
    for (int j = 0; j < IO; j++) exp[j] = (((j + IO - 1) % IO) % 2) == 0;
    Test_en = 1'b1;
    sc_head = 1'b0;
    tick;
    n_cmp++;
    if (pad_out !== exp) begin n_err++; $display("FAIL toggle_out got %h want %h", pad_out, exp); end
  endtask
  task automatic test_cfg_hold;
    prog_clk = 1'b0;
    ccff_head = 1'b0;
    Test_en = 1'b1;
    repeat (10) tick;
    n_cmp += 2;
    if (pad_dir !== '0) begin n_err++; $display("FAIL hold_dir got %h want 0", pad_dir); end
    if (ccff_tail !== 1'b1) begin n_err++; $display("FAIL hold_tail got %b want 1", ccff_tail); end
  endtask
  initial begin
    test_reset;
    test_scan_pulse(0);
    test_reset;
    test_scan_pulse(1000);
    test_config;
    test_config_order;
    test_capture;
    test_isolation;
    test_mode_toggle;
    test_cfg_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end
endmodule
